// File: rtl/dcache_ctrl_pkg.sv
// cache_pkg: shared widths, FSM state type and address-field helpers for dcache_ctrl.
package cache_pkg;

   localparam int unsigned DEF_ADDR_W      = 32;
   localparam int unsigned DEF_DATA_W      = 32;
   localparam int unsigned DEF_INDEX_W     = 3;
   localparam int unsigned DEF_BLOCK_WORDS = 4;

   localparam int unsigned OFFSET_W = 4;
   localparam int unsigned WORD_W   = 2;
   localparam int unsigned BLOCK_W  = DEF_BLOCK_WORDS * DEF_DATA_W;
   localparam int unsigned TAG_W    = DEF_ADDR_W - DEF_INDEX_W - OFFSET_W;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WRITE_BACK = 2'd1,
      ALLOCATE   = 2'd2
   } state_t;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [DEF_ADDR_W-1:0] a);
      return a[DEF_ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [DEF_INDEX_W-1:0] addr_index(input logic [DEF_ADDR_W-1:0] a);
      return a[OFFSET_W +: DEF_INDEX_W];
   endfunction

   function automatic logic [WORD_W-1:0] addr_word(input logic [DEF_ADDR_W-1:0] a);
      return a[2 +: WORD_W];
   endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: CPU-side access strobes and the block-transfer memory bus.
// The cache is the slave modport; the CPU/memory environment is the master.
interface dcache_ctrl_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LINE_W = 128
);

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              stall;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_ready;

   modport slave (
      input  mem_read, mem_write, addr, wdata, mem_rdata, mem_ready,
      output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output mem_read, mem_write, addr, wdata, mem_rdata, mem_ready,
      input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/dcache_ctrl_cache_array.sv
// cache_array: per-line valid/dirty/tag/data storage with one read port and
// one write port (single-word store or full-line fill).
module cache_array
   import cache_pkg::*;
#(
   parameter int unsigned INDEX_W   = DEF_INDEX_W,
   parameter int unsigned TAG_BITS  = TAG_W,
   parameter int unsigned LINE_W    = BLOCK_W,
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned WORD_BITS = WORD_W
) (
   input  logic                 clk,
   input  logic                 rst,
   // read port
   input  logic [INDEX_W-1:0]   rd_index_i,
   output logic                 rd_valid_o,
   output logic                 rd_dirty_o,
   output logic [TAG_BITS-1:0]  rd_tag_o,
   output logic [LINE_W-1:0]    rd_data_o,
   // write port
   input  logic [INDEX_W-1:0]   wr_index_i,
   input  logic                 wr_word_en_i,
   input  logic [WORD_BITS-1:0] wr_word_i,
   input  logic [DATA_W-1:0]    wr_wdata_i,
   input  logic                 wr_blk_en_i,
   input  logic [TAG_BITS-1:0]  wr_tag_i,
   input  logic [LINE_W-1:0]    wr_blk_i
);

   localparam int unsigned NUM_LINES = 1 << INDEX_W;

   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [NUM_LINES-1:0] dirty_q, dirty_d;
   logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
   logic [LINE_W-1:0]    data_q [NUM_LINES];

   assign rd_valid_o = valid_q[rd_index_i];
   assign rd_dirty_o = dirty_q[rd_index_i];
   assign rd_tag_o   = tag_q[rd_index_i];
   assign rd_data_o  = data_q[rd_index_i];

   // A fill leaves the line valid and clean; a word store marks it dirty.
   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (wr_blk_en_i) begin
         valid_d[wr_index_i] = 1'b1;
         dirty_d[wr_index_i] = 1'b0;
      end else if (wr_word_en_i) begin
         dirty_d[wr_index_i] = 1'b1;
      end
   end

   // Status bits: reset invalidates every line and drops any dirty data.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   // Tag and data storage: not reset, only meaningful while valid is set.
   always_ff @(posedge clk) begin
      if (wr_blk_en_i) begin
         tag_q[wr_index_i]  <= wr_tag_i;
         data_q[wr_index_i] <= wr_blk_i;
      end else if (wr_word_en_i) begin
         data_q[wr_index_i][wr_word_i*DATA_W +: DATA_W] <= wr_wdata_i;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache.
// Hits complete with zero stall; misses stall the datapath while the FSM
// writes back a dirty victim and fetches the missing line.
module dcache_ctrl
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned INDEX_W     = DEF_INDEX_W,
   parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS
) (
   input logic          clk,
   input logic          rst,
   dcache_ctrl_if.slave bus
);

   localparam int unsigned LINE_W = BLOCK_WORDS * DATA_W;

   state_t              state_q, state_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;

   logic [TAG_W-1:0]    req_tag;
   logic [INDEX_W-1:0]  req_index;
   logic [WORD_W-1:0]   req_word;

   logic                line_valid;
   logic                line_dirty;
   logic [TAG_W-1:0]    line_tag;
   logic [LINE_W-1:0]   line_data;

   logic                access;
   logic                hit;
   logic                wr_word_en;
   logic                wr_blk_en;
   logic                stall;
   logic [DATA_W-1:0]   rdata;
   logic                unused_addr_bits;

   assign req_tag          = addr_tag(bus.addr);
   assign req_index        = addr_index(bus.addr);
   assign req_word         = addr_word(bus.addr);
   assign unused_addr_bits = ^bus.addr[1:0];

   cache_array #(
      .INDEX_W   (INDEX_W),
      .TAG_BITS  (TAG_W),
      .LINE_W    (LINE_W),
      .DATA_W    (DATA_W),
      .WORD_BITS (WORD_W)
   ) u_array (
      .clk          (clk),
      .rst          (rst),
      .rd_index_i   (req_index),
      .rd_valid_o   (line_valid),
      .rd_dirty_o   (line_dirty),
      .rd_tag_o     (line_tag),
      .rd_data_o    (line_data),
      .wr_index_i   (req_index),
      .wr_word_en_i (wr_word_en),
      .wr_word_i    (req_word),
      .wr_wdata_i   (bus.wdata),
      .wr_blk_en_i  (wr_blk_en),
      .wr_tag_i     (req_tag),
      .wr_blk_i     (bus.mem_rdata)
   );

   assign access = bus.mem_read | bus.mem_write;
   assign hit    = line_valid & (line_tag == req_tag);

   // Next-state, hit handling and the bus register updates. The bus
   // registers are loaded on the transition into a state so they are
   // already valid in its first cycle and hold until mem_ready.
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      stall       = 1'b0;
      rdata       = '0;
      wr_word_en  = 1'b0;
      wr_blk_en   = 1'b0;

      case (state_q)
         IDLE: begin
            if (access) begin
               if (hit) begin
                  if (bus.mem_write) begin
                     wr_word_en = 1'b1;
                  end else begin
                     rdata = line_data[req_word*DATA_W +: DATA_W];
                  end
               end else begin
                  stall     = 1'b1;
                  mem_req_d = 1'b1;
                  if (line_valid && line_dirty) begin
                     state_d     = WRITE_BACK;
                     mem_we_d    = 1'b1;
                     mem_addr_d  = {line_tag, req_index, {OFFSET_W{1'b0}}};
                     mem_wdata_d = line_data;
                  end else begin
                     state_d    = ALLOCATE;
                     mem_we_d   = 1'b0;
                     mem_addr_d = {req_tag, req_index, {OFFSET_W{1'b0}}};
                  end
               end
            end
         end

         WRITE_BACK: begin
            stall = 1'b1;
            if (bus.mem_ready) begin
               state_d    = ALLOCATE;
               mem_we_d   = 1'b0;
               mem_addr_d = {req_tag, req_index, {OFFSET_W{1'b0}}};
            end
         end

         ALLOCATE: begin
            stall = 1'b1;
            if (bus.mem_ready) begin
               wr_blk_en = 1'b1;
               state_d   = IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end
         end

         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
         end
      endcase
   end

   // FSM state and registered memory-bus outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.rdata     = rdata;
   assign bus.stall     = stall;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed, table-driven checks of dcache_ctrl hits plus
// hand-written miss, write-back and reset sequences.
module tb_dcache_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   localparam logic [127:0] F0 = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
   localparam logic [127:0] F1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
   localparam logic [127:0] F2 = {32'h5A5A0004, 32'h5A5A0003, 32'h5A5A0002, 32'h5A5A0001};
   localparam logic [127:0] F3 = {32'h33330003, 32'h33330002, 32'h33330001, 32'h33330000};
   localparam logic [127:0] F4 = {32'h99990003, 32'h99990002, 32'h99990001, 32'h99990000};
   localparam logic [127:0] FL = {32'hBAD00003, 32'hBAD00002, 32'hBAD00001, 32'hBAD00000};

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_stall;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [8];

   dcache_ctrl_if #(.ADDR_W(32), .DATA_W(32), .LINE_W(128)) bus ();

   dcache_ctrl #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .INDEX_W     (3),
      .BLOCK_WORDS (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
      bus.mem_read  = rd;
      bus.mem_write = wr;
      bus.addr      = a;
      bus.wdata     = wd;
   endtask

   // Called with the missing access already applied in an IDLE cycle.
   task automatic run_miss(input string nm, input bit dirty, input logic [31:0] wb_addr,
                           input logic [31:0] al_addr, input int n_wb, input int n_al,
                           input logic [127:0] fill, input logic [127:0] exp_wb);
      int stalls;
      stalls = 0;
      chk({nm, "_stall_detect"}, bus.stall, 1'b1);
      chk({nm, "_req_detect"}, bus.mem_req, 1'b0);
      if (bus.stall) stalls++;
      if (dirty) begin
         for (int i = 0; i < n_wb; i++) begin
            tick();
            bus.mem_ready = 1'b0;
            if (bus.stall) stalls++;
            chk({nm, "_wb_req"}, bus.mem_req, 1'b1);
            chk({nm, "_wb_we"}, bus.mem_we, 1'b1);
            chk({nm, "_wb_addr"}, bus.mem_addr, wb_addr);
            chk({nm, "_wb_data"}, bus.mem_wdata, exp_wb);
            if (i == n_wb - 1) bus.mem_ready = 1'b1;
         end
      end
      for (int i = 0; i < n_al; i++) begin
         tick();
         bus.mem_ready = 1'b0;
         bus.mem_rdata = '0;
         if (bus.stall) stalls++;
         chk({nm, "_al_req"}, bus.mem_req, 1'b1);
         chk({nm, "_al_we"}, bus.mem_we, 1'b0);
         chk({nm, "_al_addr"}, bus.mem_addr, al_addr);
         if (i == n_al - 1) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = fill;
         end
      end
      tick();
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      #1;
      chk({nm, "_stall_done"}, bus.stall, 1'b0);
      chk({nm, "_req_done"}, bus.mem_req, 1'b0);
      chk({nm, "_stall_cycles"}, stalls, 1 + (dirty ? n_wb : 0) + n_al);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // line 4 holds tag 0 filled with F0 when these run
      vecs[0] = '{1'b0, 1'b1, 32'h44, 32'h12345678, 1'b0, 32'h0};
      vecs[1] = '{1'b1, 1'b0, 32'h44, 32'h0,        1'b0, 32'h12345678};
      vecs[2] = '{1'b1, 1'b0, 32'h40, 32'h0,        1'b0, 32'hAAAAAAAA};
      vecs[3] = '{1'b1, 1'b0, 32'h4C, 32'h0,        1'b0, 32'hDDDDDDDD};
      vecs[4] = '{1'b1, 1'b0, 32'h43, 32'h0,        1'b0, 32'hAAAAAAAA};
      vecs[5] = '{1'b0, 1'b0, 32'hC0, 32'h0,        1'b0, 32'h0};
      vecs[6] = '{1'b1, 1'b1, 32'h48, 32'h0BADF00D, 1'b0, 32'h0};
      vecs[7] = '{1'b1, 1'b0, 32'h48, 32'h0,        1'b0, 32'h0BADF00D};

      rst = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_stall", bus.stall, 1'b0);
      chk("rst_req", bus.mem_req, 1'b0);
      chk("rst_we", bus.mem_we, 1'b0);
      chk("rst_addr", bus.mem_addr, 32'h0);
      chk("rst_wdata", bus.mem_wdata, 128'h0);
      chk("rst_rdata", bus.rdata, 32'h0);

      // Cold read miss, memory answers in the third ALLOCATE cycle.
      tick();
      drive(1'b1, 1'b0, 32'h48, 32'h0);
      #1;
      run_miss("cold", 1'b0, 32'h0, 32'h40, 0, 3, F0, 128'h0);
      chk("cold_rdata", bus.rdata, 32'hCCCCCCCC);

      // Hit vectors against the freshly filled line.
      for (int i = 0; i < 8; i++) begin
         tick();
         drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         #1;
         chk($sformatf("vec%0d_stall", i), bus.stall, vecs[i].exp_stall);
         chk($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_req", i), bus.mem_req, 1'b0);
      end

      // No access for 10 cycles: never stalls, never requests.
      for (int i = 0; i < 10; i++) begin
         tick();
         drive(1'b0, 1'b0, 32'hC0, 32'h0);
         #1;
         chk("idle_stall", bus.stall, 1'b0);
         chk("idle_req", bus.mem_req, 1'b0);
      end

      // Dirty conflict: 0xC0 evicts the modified 0x40 line.
      tick();
      drive(1'b1, 1'b0, 32'hC0, 32'h0);
      #1;
      run_miss("dirty", 1'b1, 32'h40, 32'hC0, 2, 2, F1,
               {32'hDDDDDDDD, 32'h0BADF00D, 32'h12345678, 32'hAAAAAAAA});
      chk("dirty_rdata", bus.rdata, 32'h11111111);

      // Clean conflict: the 0xC0 line is clean, so no write-back.
      tick();
      drive(1'b1, 1'b0, 32'h40, 32'h0);
      #1;
      run_miss("clean", 1'b0, 32'h0, 32'h40, 0, 1, F2, 128'h0);
      chk("clean_rdata", bus.rdata, 32'h5A5A0001);

      // Minimum dirty miss: ready in the first cycle of each state.
      tick();
      drive(1'b0, 1'b1, 32'h48, 32'hFEEDFACE);
      #1;
      chk("min_whit_stall", bus.stall, 1'b0);
      tick();
      drive(1'b1, 1'b0, 32'hC0, 32'h0);
      #1;
      run_miss("mindirty", 1'b1, 32'h40, 32'hC0, 1, 1, F1,
               {32'h5A5A0004, 32'hFEEDFACE, 32'h5A5A0002, 32'h5A5A0001});
      chk("mindirty_rdata", bus.rdata, 32'h11111111);

      // Store miss: the store merges into the fetched line on retry.
      tick();
      drive(1'b0, 1'b1, 32'h2C, 32'h77777777);
      #1;
      run_miss("wmiss", 1'b0, 32'h0, 32'h20, 0, 2, F3, 128'h0);
      tick();
      drive(1'b1, 1'b0, 32'h2C, 32'h0);
      #1;
      chk("wmiss_merged", bus.rdata, 32'h77777777);
      tick();
      drive(1'b1, 1'b0, 32'h24, 32'h0);
      #1;
      chk("wmiss_other", bus.rdata, 32'h33330001);

      // Make line 4 dirty, then reset in the middle of an ALLOCATE.
      tick();
      drive(1'b0, 1'b1, 32'hC8, 32'hABCDEF01);
      #1;
      chk("pre_rst_whit", bus.stall, 1'b0);
      tick();
      drive(1'b1, 1'b0, 32'h100, 32'h0);
      #1;
      chk("mid_stall", bus.stall, 1'b1);
      tick();
      chk("mid_req", bus.mem_req, 1'b1);
      chk("mid_addr", bus.mem_addr, 32'h100);
      rst = 1'b1;
      drive(1'b0, 1'b0, 32'h100, 32'h0);
      tick();
      rst = 1'b0;
      #1;
      chk("mid_rst_req", bus.mem_req, 1'b0);
      chk("mid_rst_stall", bus.stall, 1'b0);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = FL;
      tick();
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      #1;
      chk("late_ready_req", bus.mem_req, 1'b0);
      chk("late_ready_stall", bus.stall, 1'b0);

      tick();
      drive(1'b1, 1'b0, 32'h100, 32'h0);
      #1;
      run_miss("rerd", 1'b0, 32'h0, 32'h100, 0, 1, F4, 128'h0);
      chk("rerd_rdata", bus.rdata, 32'h99990000);

      // Dirty lines were discarded by reset: refetch without write-back.
      tick();
      drive(1'b1, 1'b0, 32'hC8, 32'h0);
      #1;
      run_miss("discard4", 1'b0, 32'h0, 32'hC0, 0, 1, F1, 128'h0);
      chk("discard4_rdata", bus.rdata, 32'h33333333);
      tick();
      drive(1'b1, 1'b0, 32'h2C, 32'h0);
      #1;
      run_miss("discard2", 1'b0, 32'h0, 32'h20, 0, 1, F3, 128'h0);
      chk("discard2_rdata", bus.rdata, 32'h33330003);

      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache with its miss-handling state machine. It sits directly downstream of the main decoder. It consumes the decoder's `mem_read`/`mem_write` strobes together with the ALU-computed address and the rs2 store data, and returns load data to the write-back mux. On a miss it raises `stall` to freeze the single-cycle datapath while it exchanges whole blocks with main memory over a request/ready handshake.

## Interface
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: CPU word width. All accesses are word accesses; `addr[1:0]` is ignored.
- `INDEX_W`, 3: line-index bits, giving 8 lines.
- `BLOCK_WORDS`, 4: words per line. Block is 128 bits; word offset is `addr[3:2]`.
- `clk` in 1: single clock. Everything is rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `mem_read` in 1: load strobe from the decoder.
- `mem_write` in 1: store strobe from the decoder.
- `addr` in ADDR_W: byte address from the ALU.
- `wdata` in DATA_W: store data.
- `rdata` out DATA_W: load data. Combinational; 0 unless there is a read hit in IDLE.
- `stall` out 1: freezes the PC and register write.
- `mem_req` out 1: memory request. Held until `mem_ready`.
- `mem_we` out 1: 1 = block write-back, 0 = block fetch.
- `mem_addr` out ADDR_W: block-aligned address (`[3:0]`=0).
- `mem_wdata` out 128: victim block. Word 0 is in `[31:0]`.
- `mem_rdata` in 128: fetched block. Same word order as `mem_wdata`.
- `mem_ready` in 1: one-cycle completion pulse from memory.

## Operation
- **Address split:** tag = `addr[ADDR_W-1:INDEX_W+4]` (25 bits at defaults); index = `addr[INDEX_W+3:4]`; word = `addr[3:2]`.
- **Per-line storage:** valid, dirty, tag, and a 128-bit data block.
- **Access and hit:** access = `mem_read | mem_write`. hit = valid[index] & (tag[index] == tag).
- **Write priority:** if both strobes are high, the access is treated as a write.
- **States:** IDLE, WRITE_BACK, ALLOCATE.
- **IDLE, no access:** `stall`=0, `mem_req`=0, no state change.
- **IDLE, read hit:** `rdata` = selected word in the same cycle; `stall`=0.
- **IDLE, write hit:** the selected word is replaced at the clock edge and dirty is set; `stall`=0.
- **IDLE, miss:** `stall`=1 combinationally.
  - Next state is WRITE_BACK if the victim is valid and dirty.
  - Otherwise next state is ALLOCATE.
- **WRITE_BACK:**
  - Drives `mem_req`=1, `mem_we`=1, `mem_addr`={victim tag, index, 4'b0}, `mem_wdata`=victim block.
  - On `mem_ready`, moves to ALLOCATE.
- **ALLOCATE:**
  - Drives `mem_req`=1, `mem_we`=0, `mem_addr`={tag, index, 4'b0}.
  - On `mem_ready`, the line is loaded from `mem_rdata` with valid=1, dirty=0, tag updated, and the state returns to IDLE.
- **Retry:** the CPU holds `mem_read`, `mem_write`, `addr` and `wdata` stable while `stall`=1. Back in IDLE the access hits and completes as a normal hit; a store merges into the freshly fetched line.
- **Bus rules:**
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay constant from the first request cycle through the `mem_ready` cycle.
  - `mem_ready` is ignored in IDLE.
  - Memory latency is unbounded; there is no timeout.

## Timing
- **Reset values:** state=IDLE, all valid=0, all dirty=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `stall` follows the IDLE rules.
  - Tag and data arrays are not reset.
- **Hit:** 0 stall cycles. Load data is valid in the access cycle; store data is written at the end of it.
- **Clean miss:** stall cycles = 1 (IDLE detect) + N_alloc, where N_alloc ≥ 1 is the ALLOCATE cycles up to and including the `mem_ready` cycle. The hit completes in the following cycle.
- **Dirty miss:** stall cycles = 1 + N_wb + N_alloc.
- **`mem_ready` timing:** a `mem_ready` seen in the first cycle of a state is honoured. The minimum dirty miss is therefore 3 stall cycles.
- **Reset mid-miss:** `rst` at any edge forces IDLE and invalidates all lines. `mem_req` is 0 from the next cycle. Dirty data is discarded. A `mem_ready` arriving later is ignored.
- **Registered outputs:** `mem_*` are registered. `stall` and `rdata` are combinational from state, inputs and arrays.

## Structure
- **Package `cache_pkg`:**
  - state enum {IDLE, WRITE_BACK, ALLOCATE};
  - localparams `OFFSET_W`=4, `BLOCK_W`=128, `TAG_W`;
  - tag/index/word extraction functions.
- **Sub-module `cache_array`:** valid/dirty/tag/data storage. It has one read port and one write port (word-write or full-block write with tag/valid/dirty update) and clears valid/dirty on `rst`.
- **Top level:** `dcache_ctrl` holds the FSM, hit logic and bus drivers.

## Test plan
- **Cold read miss:** after reset, read 0x48.
  - Expect `stall`=1, ALLOCATE with `mem_addr`=0x40, `mem_we`=0.
  - Return `mem_ready` after 3 cycles with `mem_rdata`={DDDDDDDD,CCCCCCCC,BBBBBBBB,AAAAAAAA}.
  - Next cycle: `stall`=0, `rdata`=0xCCCCCCCC.
- **Write hit:** write 0x44 ← 0x12345678.
  - Expect `stall`=0 and no `mem_req`.
  - Then read 0x44: `rdata`=0x12345678 with `stall`=0.
- **Dirty conflict:** read 0xC0 (index 4, tag 1).
  - Expect WRITE_BACK with `mem_addr`=0x40, `mem_we`=1, `mem_wdata[63:32]`=0x12345678.
  - Then ALLOCATE with `mem_addr`=0xC0.
  - Total stall = 1 + N_wb + N_alloc.
- **Clean conflict:** read 0x40 again.
  - Expect no write-back; ALLOCATE directly with `mem_addr`=0x40.
  - Read returns the memory's word 0.
- **Reset mid-ALLOCATE:** assert `rst` one cycle while `mem_req`=1.
  - Expect `mem_req`=0 the next cycle.
  - A late `mem_ready` is ignored.
  - Re-reading the same address misses again.
- **Idle / simultaneous strobes:**
  - `mem_read`=`mem_write`=0 for 10 cycles: `stall`=0 and `mem_req`=0 throughout.
  - Both strobes high on a hit: treated as a write, dirty set.
